// File: rtl/rx_parser_if.sv
// Bus between the UART receiver, the CPU and the rx_parser.
// The slave side is the parser; the master side is the receiver/CPU.
interface rx_parser_if #(
    parameter int W = 32
);
    logic [7:0]   d_rx;
    logic         vld_rx;
    logic         rdy_rx;
    logic         req_rx;
    logic [1:0]   mode_rx;
    logic [W-1:0] din_rx;
    logic         flag_rx;
    logic         err_rx;
    logic [7:0]   ndig_rx;
    logic         ack_rx;

    modport slave (
        input  d_rx, vld_rx, req_rx, mode_rx,
        output rdy_rx, din_rx, flag_rx, err_rx, ndig_rx, ack_rx
    );

    modport master (
        output d_rx, vld_rx, req_rx, mode_rx,
        input  rdy_rx, din_rx, flag_rx, err_rx, ndig_rx, ack_rx
    );
endinterface

// File: rtl/rx_parser.sv
// rx_parser: turns a stream of ASCII characters into one item per CPU
// request -- a raw byte, a hex word or a saturating unsigned decimal word.
module rx_parser #(
    parameter int W      = 32,
    parameter int HEXDIG = W / 4
) (
    input logic        clk,
    input logic        rstn,
    rx_parser_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [1:0] M_BYTE = 2'b00;
    localparam logic [1:0] M_DEC  = 2'b10;

    localparam logic [7:0] C_BS = 8'h08;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_CR = 8'h0D;
    localparam logic [7:0] C_SP = 8'h20;

    localparam logic [7:0]   HEXDIG_C = 8'(HEXDIG);
    localparam logic [W+3:0] TEN      = (W + 4)'(10);

    logic [1:0]   state_q, state_d;
    logic [1:0]   mode_q,  mode_d;
    logic [W-1:0] acc_q,   acc_d;
    logic [7:0]   cnt_q,   cnt_d;
    logic         err_q,   err_d;
    logic [W-1:0] din_q,   din_d;
    logic         flag_q,  flag_d;
    logic         erro_q,  erro_d;
    logic [7:0]   ndig_q,  ndig_d;

    logic         is_dec;
    logic         is_hex;
    logic [3:0]   dig_val;
    logic [W+3:0] dec_wide;
    logic         dec_ovf;
    logic [W-1:0] hex_acc;
    logic [7:0]   hex_cnt;

    logic         fin;
    logic [W-1:0] fin_acc;
    logic [7:0]   fin_cnt;

    // Classify the incoming character and extract its digit value.
    always_comb begin
        is_dec  = 1'b0;
        is_hex  = 1'b0;
        dig_val = 4'd0;
        if (bus.d_rx >= 8'h30 && bus.d_rx <= 8'h39) begin
            is_dec  = 1'b1;
            is_hex  = 1'b1;
            dig_val = bus.d_rx[3:0];
        end else if ((bus.d_rx >= 8'h61 && bus.d_rx <= 8'h66) ||
                     (bus.d_rx >= 8'h41 && bus.d_rx <= 8'h46)) begin
            is_hex  = 1'b1;
            dig_val = bus.d_rx[3:0] + 4'd9;
        end
    end

    // Decimal step kept 4 bits wider so overflow past 2^W-1 is visible.
    assign dec_wide = ({4'b0000, acc_q} * TEN) + {{W{1'b0}}, dig_val};
    assign dec_ovf  = |dec_wide[W+3:W];
    assign hex_acc  = {acc_q[W-5:0], dig_val};
    assign hex_cnt  = cnt_q + 8'd1;

    // Next-state logic: request latch, per-character parsing, completion.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        din_d   = din_q;
        flag_d  = flag_q;
        erro_d  = erro_q;
        ndig_d  = ndig_q;
        fin     = 1'b0;
        fin_acc = acc_q;
        fin_cnt = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_rx) begin
                    mode_d  = bus.mode_rx;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_RECV;
                end
            end

            S_RECV: begin
                if (bus.vld_rx) begin
                    if (mode_q == M_BYTE) begin
                        // Byte mode takes the first character verbatim.
                        din_d   = W'(bus.d_rx);
                        flag_d  = 1'b1;
                        erro_d  = err_q;
                        ndig_d  = 8'd1;
                        state_d = S_ACK;
                    end else if (bus.d_rx == C_CR) begin
                        // Carriage return is dropped in both word modes.
                    end else if (bus.d_rx == C_LF || (bus.d_rx == C_SP && cnt_q != 8'd0)) begin
                        fin = 1'b1;
                    end else if (bus.d_rx == C_SP) begin
                        // Leading spaces are skipped.
                    end else if (mode_q == M_DEC) begin
                        if (is_dec) begin
                            acc_d = dec_ovf ? '1 : dec_wide[W-1:0];
                            if (dec_ovf) begin
                                err_d = 1'b1;
                            end
                            cnt_d = (cnt_q == 8'hFF) ? cnt_q : hex_cnt;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        // Hex mode (mode 01 and reserved 11).
                        if (is_hex) begin
                            acc_d = hex_acc;
                            cnt_d = hex_cnt;
                            if (hex_cnt == HEXDIG_C) begin
                                fin     = 1'b1;
                                fin_acc = hex_acc;
                                fin_cnt = hex_cnt;
                            end
                        end else if (bus.d_rx == C_BS) begin
                            if (cnt_q != 8'd0) begin
                                acc_d = acc_q >> 4;
                                cnt_d = cnt_q - 8'd1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            din_d   = (fin_cnt != 8'd0) ? fin_acc : '0;
            flag_d  = (fin_cnt != 8'd0);
            erro_d  = err_q;
            ndig_d  = fin_cnt;
            state_d = S_ACK;
        end
    end

    // State and result registers, cleared asynchronously by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            mode_q  <= M_BYTE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            din_q   <= '0;
            flag_q  <= 1'b0;
            erro_q  <= 1'b0;
            ndig_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            din_q   <= din_d;
            flag_q  <= flag_d;
            erro_q  <= erro_d;
            ndig_q  <= ndig_d;
        end
    end

    assign bus.rdy_rx  = (state_q == S_RECV);
    assign bus.ack_rx  = (state_q == S_ACK);
    assign bus.din_rx  = din_q;
    assign bus.flag_rx = flag_q;
    assign bus.err_rx  = erro_q;
    assign bus.ndig_rx = ndig_q;

endmodule

// File: tb/tb_rx_parser.sv
// Self-checking bench for rx_parser: a string-level reference parser
// predicts each transaction; a negedge process compares every cycle.
module tb_rx_parser;

    localparam int W      = 32;
    localparam int HEXDIG = W / 4;

    typedef logic [7:0] ch_t;
    typedef ch_t chq_t[$];

    typedef struct {
        int           used;
        logic [W-1:0] din;
        bit           flag;
        bit           err;
        int           ndig;
    } res_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    int total = 0;
    int bad   = 0;

    logic         exp_rdy  = 1'b0;
    logic         exp_ack  = 1'b0;
    logic [W-1:0] exp_din  = '0;
    logic         exp_flag = 1'b0;
    logic         exp_err  = 1'b0;
    logic [7:0]   exp_ndig = '0;

    always #5 clk = ~clk;

    rx_parser_if #(.W(W)) bus ();

    rx_parser #(.W(W), .HEXDIG(HEXDIG)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference parser: walks the character list and reports where the
    // transaction completes and what the result registers must hold.
    function automatic res_t model(input logic [1:0] m, input chq_t cs);
        res_t         r;
        logic [127:0] v;
        logic [127:0] maxv;
        int           n;
        bit           e;
        v      = '0;
        maxv   = (128'd1 << W) - 128'd1;
        n      = 0;
        e      = 1'b0;
        r.used = -1;
        r.din  = '0;
        r.flag = 1'b0;
        r.err  = 1'b0;
        r.ndig = 0;
        for (int i = 0; i < cs.size(); i++) begin
            int c;
            int dv;
            bit done;
            c    = int'(cs[i]);
            dv   = -1;
            done = 1'b0;
            if (m == 2'b00) begin
                r.used = i + 1;
                r.din  = W'(cs[i]);
                r.flag = 1'b1;
                r.ndig = 1;
                return r;
            end
            if (c >= 48 && c <= 57) dv = c - 48;
            else if (m != 2'b10 && c >= 97 && c <= 102) dv = c - 87;
            else if (m != 2'b10 && c >= 65 && c <= 70) dv = c - 55;

            if (c == 13) begin
            end else if (c == 10 || (c == 32 && n > 0)) begin
                done = 1'b1;
            end else if (c == 32) begin
            end else if (dv >= 0) begin
                if (m == 2'b10) begin
                    v = v * 10 + 128'(dv);
                    if (v > maxv) begin
                        v = maxv;
                        e = 1'b1;
                    end
                    if (n < 255) n++;
                end else begin
                    v = (v * 16 + 128'(dv)) & maxv;
                    n++;
                    if (n == HEXDIG) done = 1'b1;
                end
            end else if (m != 2'b10 && c == 8) begin
                if (n > 0) begin
                    v = v / 16;
                    n--;
                end
            end else begin
                e = 1'b1;
            end

            if (done) begin
                r.used = i + 1;
                r.flag = (n > 0);
                r.din  = (n > 0) ? v[W-1:0] : '0;
                r.err  = e;
                r.ndig = n;
                return r;
            end
        end
        return r;
    endfunction

    function automatic chq_t s2q(input string s);
        chq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(ch_t'(s[i]));
        return q;
    endfunction

    function automatic chq_t rand_chars(input logic [1:0] m);
        chq_t q;
        int   len;
        if (m == 2'b10 && $urandom_range(0, 3) == 0) begin
            len = $urandom_range(8, 12);
            for (int i = 0; i < len; i++) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
        end else begin
            len = $urandom_range(0, 14);
            for (int i = 0; i < len; i++) begin
                int k;
                k = $urandom_range(0, 99);
                if (m == 2'b00 || k >= 88) q.push_back(8'($urandom));
                else if (k < 45) q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                else if (k < 52) q.push_back(8'h61 + 8'($urandom_range(0, 5)));
                else if (k < 60) q.push_back(8'h41 + 8'($urandom_range(0, 5)));
                else if (k < 68) q.push_back(8'h20);
                else if (k < 74) q.push_back(8'h0D);
                else if (k < 82) q.push_back(8'h08);
                else q.push_back(8'h0A);
            end
        end
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_rx = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.vld_rx  = 1'($urandom);
            bus.d_rx    = 8'($urandom);
            bus.mode_rx = 2'($urandom);
            cycle();
        end
    endtask

    // Runs one transaction from IDLE; leaves the DUT in IDLE with req_rx = keep_req.
    task automatic txn(input logic [1:0] m, input chq_t cs, input bit keep_req);
        res_t r;
        r = model(m, cs);
        check("txn_completes", 64'(r.used > 0), 64'd1);
        if (r.used <= 0) return;

        bus.req_rx  = 1'b1;
        bus.mode_rx = m;
        cycle();
        exp_rdy = 1'b1;
        check("rdy_on_entry", 64'(bus.rdy_rx), 64'd1);
        bus.req_rx  = 1'($urandom);
        bus.mode_rx = 2'($urandom);

        for (int i = 0; i < r.used; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                bus.vld_rx = 1'b0;
                bus.d_rx   = 8'($urandom);
                cycle();
            end
            bus.vld_rx = 1'b1;
            bus.d_rx   = cs[i];
            cycle();
            bus.req_rx  = 1'($urandom);
            bus.mode_rx = 2'($urandom);
        end

        bus.vld_rx = 1'($urandom);
        bus.d_rx   = 8'($urandom);
        exp_rdy  = 1'b0;
        exp_ack  = 1'b1;
        exp_din  = r.din;
        exp_flag = r.flag;
        exp_err  = r.err;
        exp_ndig = 8'(r.ndig);
        cycle();
        exp_ack    = 1'b0;
        bus.req_rx = keep_req;
    endtask

    task automatic directed(input string name, input logic [1:0] m, input string s,
                            input logic [W-1:0] din, input bit flag, input bit err,
                            input int nd, input bit keep);
        res_t r;
        r = model(m, s2q(s));
        check({name, "_model_din"},  64'(r.din),  64'(din));
        check({name, "_model_flag"}, 64'(r.flag), 64'(flag));
        check({name, "_model_err"},  64'(r.err),  64'(err));
        check({name, "_model_ndig"}, 64'(r.ndig), 64'(nd));
        txn(m, s2q(s), keep);
        check({name, "_din"},  64'(bus.din_rx),  64'(din));
        check({name, "_flag"}, 64'(bus.flag_rx), 64'(flag));
        check({name, "_err"},  64'(bus.err_rx),  64'(err));
        check({name, "_ndig"}, 64'(bus.ndig_rx), 64'(nd));
    endtask

    // Every-cycle comparison of all DUT outputs against the expectations.
    always @(negedge clk) begin
        check("rdy_rx",  64'(bus.rdy_rx),  64'(exp_rdy));
        check("ack_rx",  64'(bus.ack_rx),  64'(exp_ack));
        check("din_rx",  64'(bus.din_rx),  64'(exp_din));
        check("flag_rx", 64'(bus.flag_rx), 64'(exp_flag));
        check("err_rx",  64'(bus.err_rx),  64'(exp_err));
        check("ndig_rx", 64'(bus.ndig_rx), 64'(exp_ndig));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.d_rx    = 8'h00;
        bus.vld_rx  = 1'b0;
        bus.req_rx  = 1'b0;
        bus.mode_rx = 2'b00;
        #1 rstn = 1'b0;
        #1;
        check("reset_rdy",  64'(bus.rdy_rx),  64'd0);
        check("reset_ack",  64'(bus.ack_rx),  64'd0);
        check("reset_din",  64'(bus.din_rx),  64'd0);
        check("reset_ndig", 64'(bus.ndig_rx), 64'd0);
        cycle();
        cycle();
        rstn = 1'b1;
        idle(3);

        directed("hex8",     2'b01, "1A2b3C4d",        32'h1A2B3C4D, 1'b1, 1'b0, 8,  1'b0);
        directed("hex_ff",   2'b01, "  ff\015\n",      32'h000000FF, 1'b1, 1'b0, 2,  1'b0);
        directed("hex_empty",2'b01, "\015\n",          32'h00000000, 1'b0, 1'b0, 0,  1'b0);
        directed("hex_bs",   2'b01, "12\0103g\n",      32'h00000013, 1'b1, 1'b1, 2,  1'b0);
        directed("dec_max",  2'b10, "4294967295\n",    32'hFFFFFFFF, 1'b1, 1'b0, 10, 1'b0);
        directed("dec_ovf",  2'b10, "4294967296\n",    32'hFFFFFFFF, 1'b1, 1'b1, 10, 1'b0);
        directed("dec_sp",   2'b10, "12a 9\n",         32'd12,       1'b1, 1'b1, 2,  1'b0);
        directed("mode11",   2'b11, "beef\n",          32'h0000BEEF, 1'b1, 1'b0, 4,  1'b0);
        directed("byte_A",   2'b00, "A",               32'h00000041, 1'b1, 1'b0, 1,  1'b1);
        check("rdy_idle_after_ack", 64'(bus.rdy_rx), 64'd0);
        directed("byte_lf",  2'b00, "\n",              32'h0000000A, 1'b1, 1'b0, 1,  1'b0);
        idle(2);

        // Reset in the middle of a hex item after three digits.
        bus.req_rx  = 1'b1;
        bus.mode_rx = 2'b01;
        cycle();
        exp_rdy    = 1'b1;
        bus.req_rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.vld_rx = 1'b1;
            bus.d_rx   = 8'h35 + 8'(i);
            cycle();
        end
        bus.vld_rx = 1'b0;
        #2 rstn = 1'b0;
        exp_rdy  = 1'b0;
        exp_ack  = 1'b0;
        exp_din  = '0;
        exp_flag = 1'b0;
        exp_err  = 1'b0;
        exp_ndig = '0;
        #1;
        check("midrst_rdy",  64'(bus.rdy_rx),  64'd0);
        check("midrst_ack",  64'(bus.ack_rx),  64'd0);
        check("midrst_din",  64'(bus.din_rx),  64'd0);
        check("midrst_flag", 64'(bus.flag_rx), 64'd0);
        check("midrst_ndig", 64'(bus.ndig_rx), 64'd0);
        cycle();
        cycle();
        cycle();
        rstn = 1'b1;
        idle(2);
        directed("post_rst", 2'b01, "7\n", 32'h00000007, 1'b1, 1'b0, 1, 1'b0);

        // Randomized transactions in all modes.
        for (int t = 0; t < 250; t++) begin
            logic [1:0] m;
            bit         keep;
            m    = 2'($urandom);
            keep = 1'($urandom);
            txn(m, rand_chars(m), keep);
            if (!keep) idle($urandom_range(0, 3));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_parser.md
RX_PARSER -- requirements
Module: rx_parser

Interface
REQ-001 SHALL have parameter W, default 32, meaning output word width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL have parameter HEXDIG, default W/4, meaning the hex digit count that auto-completes a hex transaction.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 d_rx  in  8  ASCII character from the UART receiver.
REQ-006 vld_rx  in  1  d_rx valid.
REQ-007 rdy_rx  out  1  parser ready to accept a character.
REQ-008 req_rx  in  1  CPU request to read one item.
REQ-009 mode_rx  in  2  item type: 00 byte, 01 hex word, 10 unsigned decimal word, 11 reserved (treated as 01).
REQ-010 din_rx  out  W  parsed value, zero-extended.
REQ-011 flag_rx  out  1  1 = value present; 0 = empty line.
REQ-012 err_rx  out  1  sticky per-transaction error (invalid char or decimal overflow).
REQ-013 ndig_rx  out  8  count of digits held in din_rx.
REQ-014 ack_rx  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RECV and ACK.
REQ-016 IDLE: SHALL sample req_rx each cycle; on req_rx=1, latch mode_rx, clear accumulator, digit count and err; next state RECV.
REQ-017 SHALL drive rdy_rx combinationally, high only in RECV; a character is accepted on an edge where rdy_rx and vld_rx are both 1.
REQ-018 Byte mode: the first accepted character SHALL complete the transaction; din_rx = {0, d_rx}, flag_rx=1, ndig_rx=1, any value including 0x0A.
REQ-019 Hex mode: '0'-'9', 'a'-'f' and 'A'-'F' SHALL update acc = (acc<<4)|digit and increment the count; on reaching HEXDIG the transaction completes.
REQ-020 Decimal mode: '0'-'9' SHALL update acc = acc*10+digit at full precision.
REQ-021 Decimal mode: if the result exceeds 2^W-1, acc SHALL saturate to all ones and err is set; the count still increments, saturating at 255.
REQ-022 0x0D SHALL always be discarded.
REQ-023 0x20 SHALL be discarded when count=0 and SHALL terminate the transaction when count>0.
REQ-024 0x0A SHALL terminate the transaction; flag_rx=1 if count>0, else flag_rx=0 and din_rx=0.
REQ-025 Hex mode, 0x08 (backspace): if count>0, SHALL set acc=acc>>4 and decrement the count; if count=0, the character is ignored.
REQ-026 Decimal mode: 0x08 SHALL be treated as an invalid character.
REQ-027 Any other character SHALL set err and be discarded; parsing continues in RECV.
REQ-028 On the completing accept edge, SHALL load din_rx, flag_rx, err_rx and ndig_rx and enter ACK; ack_rx is high only in ACK, i.e. one cycle after that edge.
REQ-029 din_rx, flag_rx, err_rx and ndig_rx SHALL hold stable from ACK until the next IDLE->RECV transition.
REQ-030 ACK -> IDLE unconditionally; a req_rx still high in the following IDLE cycle SHALL start a new transaction (no implicit re-trigger inside ACK).
REQ-031 mode_rx and req_rx changes during RECV SHALL be ignored.
REQ-032 vld_rx outside RECV SHALL be ignored; the character is not consumed.

Reset
REQ-033 rstn=0 SHALL immediately force IDLE and set din_rx=0, flag_rx=0, err_rx=0, ndig_rx=0, ack_rx=0, rdy_rx=0, clear the accumulator and set the latched mode to 00.
REQ-034 Reset mid-RECV SHALL abandon the transaction with no ack_rx pulse; the first post-reset req_rx starts cleanly.

Verification
REQ-035 Hex mode, W=32, chars "1A2b3C4d" -> ack one cycle after the 8th accept; din_rx=0x1A2B3C4D, flag=1, err=0, ndig=8.
REQ-036 Hex mode, "  ff\r\n" -> din_rx=0x000000FF, ndig=2, flag=1; then "\r\n" -> din_rx=0, flag=0, ndig=0.
REQ-037 Hex mode, "12<BS>3g\n" -> din_rx=0x13, ndig=2, err=1.
REQ-038 Decimal mode, W=32, "4294967295\n" -> 0xFFFFFFFF, err=0; "4294967296\n" -> 0xFFFFFFFF, err=1.
REQ-039 Byte mode, 'A' -> din_rx=0x00000041, flag=1, ack one cycle after accept; req_rx held high through ACK -> rdy_rx high again two cycles after ack.
REQ-040 Reset asserted after 3 hex digits -> all outputs 0 with no ack; the next request plus "7\n" -> din_rx=0x7.
